// File: rtl/seg7_scan_driver.sv
// Multiplexed hex 7-segment scan driver with frame-synchronised updates,
// inter-digit dead time and optional leading-zero blanking.
module seg7_scan_driver #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg7,
    output logic                  dp,
    output logic                  frame
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [PW-1:0]       pre;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] act_val;
    logic [DIGITS-1:0]   act_dp;
    logic [4*DIGITS-1:0] pend_val;
    logic [DIGITS-1:0]   pend_dp;
    logic                pend_v;
    logic                boundary;

    logic [DIGITS-1:0]   lead_zero;
    logic                run;
    logic [3:0]          nib;
    logic                blank;
    logic [DIGITS-1:0]   an_d;
    logic [6:0]          seg_d;

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    assign boundary = (pre == '0) && (idx == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
            idx <= '0;
        end else if (pre == PRE_LAST) begin
            pre <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    // A load landing on the boundary bypasses pend and goes live at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_val  <= '0;
            act_dp   <= '0;
            pend_val <= '0;
            pend_dp  <= '0;
            pend_v   <= 1'b0;
        end else if (boundary) begin
            if (load) begin
                act_val <= value;
                act_dp  <= dp_in;
            end else if (pend_v) begin
                act_val <= pend_val;
                act_dp  <= pend_dp;
            end
            pend_v <= 1'b0;
        end else if (load) begin
            pend_val <= value;
            pend_dp  <= dp_in;
            pend_v   <= 1'b1;
        end
    end

    always_comb begin
        run       = 1'b1;
        lead_zero = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run          = run & (act_val[4*i +: 4] == 4'h0);
            lead_zero[i] = run;
        end
    end

    always_comb begin
        nib   = act_val[{idx, 2'b00} +: 4];
        blank = blank_lz && (idx != '0) && lead_zero[idx];
        seg_d = blank ? 7'b1111111 : decode(nib);
        an_d  = '1;
        if (pre != '0) an_d[idx] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an    <= '1;
            seg7  <= 7'b1111111;
            dp    <= 1'b1;
            frame <= 1'b0;
        end else begin
            an    <= an_d;
            seg7  <= seg_d;
            dp    <= ~act_dp[idx];
            frame <= boundary;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: constant vector table, directed frame
// scenarios and random traffic against a cycle-position reference model.
module tb_seg7_scan_driver;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [3:0]  an;
    logic [6:0]  seg7;
    logic        dp;
    logic        frame;

    int total = 0;
    int passed = 0;

    seg7_scan_driver #(.DIGITS(4), .REFRESH_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value),
        .dp_in(dp_in), .blank_lz(blank_lz), .an(an), .seg7(seg7),
        .dp(dp), .frame(frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] seg_tab [16];

    // Reference model: position within the 16-cycle frame is derived from
    // a plain cycle count since reset.
    int          m_cyc;
    logic [15:0] m_act;
    logic [3:0]  m_dp;
    logic [15:0] m_pend;
    logic [3:0]  m_pdp;
    logic        m_pv;

    logic [6:0]  cap [4];
    logic [3:0]  dp_low_mask;
    int          dp_low_cnt;

    typedef struct {
        logic        ld;
        logic [15:0] v;
        logic [3:0]  d;
        logic        blz;
        logic [3:0]  e_an;
        logic [6:0]  e_seg;
        logic        e_dp;
        logic        e_fr;
    } vec_t;

    vec_t vt [16];
    logic [3:0] an_seq [16];

    task automatic chk(input string nm, input logic [15:0] got,
                       input logic [15:0] exp);
        total++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        else
            passed++;
    endtask

    task automatic model_reset();
        m_cyc = 0; m_act = '0; m_dp = '0;
        m_pend = '0; m_pdp = '0; m_pv = 1'b0;
    endtask

    task automatic step();
        int p, ix, pr;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp, e_fr;
        @(posedge clk);
        p  = m_cyc % 16;
        ix = p / 4;
        pr = p % 4;
        e_an  = (pr == 0) ? 4'hF : ~(4'b0001 << ix);
        if (blank_lz && ix > 0 && (m_act >> (ix * 4)) == 16'h0)
            e_seg = 7'b1111111;
        else
            e_seg = seg_tab[m_act[ix*4 +: 4]];
        e_dp = ~m_dp[ix];
        e_fr = (p == 0);
        if (p == 0) begin
            if (load) begin
                m_act = value; m_dp = dp_in;
            end else if (m_pv) begin
                m_act = m_pend; m_dp = m_pdp;
            end
            m_pv = 1'b0;
        end else if (load) begin
            m_pend = value; m_pdp = dp_in; m_pv = 1'b1;
        end
        m_cyc++;
        #1;
        chk("model_an", 16'(an), 16'(e_an));
        chk("model_seg7", 16'(seg7), 16'(e_seg));
        chk("model_frame", 16'(frame), 16'(e_fr));
        if (e_an != 4'hF) chk("model_dp", 16'(dp), 16'(e_dp));
        @(negedge clk);
    endtask

    task automatic align();
        load = 1'b0;
        while (m_cyc % 16 != 0) step();
    endtask

    task automatic capture_frame(input logic ld, input logic [15:0] v,
                                 input logic [3:0] d);
        dp_low_mask = '0;
        dp_low_cnt  = 0;
        for (int k = 0; k < 4; k++) cap[k] = 7'h00;
        load = ld; value = v; dp_in = d;
        for (int k = 0; k < 16; k++) begin
            step();
            load = 1'b0;
            for (int dd = 0; dd < 4; dd++) begin
                if (an == ~(4'b0001 << dd)) begin
                    cap[dd] = seg7;
                    if (!dp) begin
                        dp_low_mask[dd] = 1'b1;
                        dp_low_cnt++;
                    end
                end
            end
        end
    endtask

    task automatic chk_caps(input string nm, input logic [6:0] e3,
                            input logic [6:0] e2, input logic [6:0] e1,
                            input logic [6:0] e0);
        chk({nm, "_d3"}, 16'(cap[3]), 16'(e3));
        chk({nm, "_d2"}, 16'(cap[2]), 16'(e2));
        chk({nm, "_d1"}, 16'(cap[1]), 16'(e1));
        chk({nm, "_d0"}, 16'(cap[0]), 16'(e0));
    endtask

    initial begin
        seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        an_seq = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                   4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};
        for (int i = 0; i < 16; i++)
            vt[i] = '{1'b0, 16'h0, 4'h0, 1'b0, an_seq[i],
                      7'b0000001, 1'b1, (i == 0)};

        rst_n = 1'b0; load = 1'b0; value = '0; dp_in = '0; blank_lz = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_an", 16'(an), 16'hF);
        chk("rst_seg7", 16'(seg7), 16'h7F);
        chk("rst_dp", 16'(dp), 16'h1);
        chk("rst_frame", 16'(frame), 16'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            load = vt[i].ld; value = vt[i].v;
            dp_in = vt[i].d; blank_lz = vt[i].blz;
            step();
            chk("vec_an", 16'(an), 16'(vt[i].e_an));
            chk("vec_frame", 16'(frame), 16'(vt[i].e_fr));
            if (vt[i].e_an != 4'hF) begin
                chk("vec_seg7", 16'(seg7), 16'(vt[i].e_seg));
                chk("vec_dp", 16'(dp), 16'(vt[i].e_dp));
            end
        end

        // Load mid-frame: current frame untouched, next frame fully new.
        repeat (5) step();
        load = 1'b1; value = 16'hFEDC; dp_in = 4'h0;
        step();
        align();
        capture_frame(1'b0, 16'h0, 4'h0);
        chk_caps("fedc", 7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001);
        chk("fedc_frame_next", 16'(frame), 16'h0);

        // Two loads in one frame: last wins, leading zeros blanked.
        blank_lz = 1'b1;
        repeat (3) step();
        load = 1'b1; value = 16'h1234;
        step();
        load = 1'b0;
        repeat (4) step();
        load = 1'b1; value = 16'h00A5;
        step();
        align();
        capture_frame(1'b0, 16'h0, 4'h0);
        chk_caps("twoload", 7'b1111111, 7'b1111111, 7'b0001000, 7'b0100100);

        // Load on the boundary cycle shows in that same frame.
        blank_lz = 1'b0;
        align();
        capture_frame(1'b1, 16'h3217, 4'h0);
        chk_caps("bnd", 7'b0000110, 7'b0010010, 7'b1001111, 7'b0001111);
        capture_frame(1'b0, 16'h0, 4'h0);
        chk_caps("bnd_next", 7'b0000110, 7'b0010010, 7'b1001111, 7'b0001111);

        // All-zero value with blanking and a decimal point on digit 2.
        blank_lz = 1'b1;
        align();
        capture_frame(1'b1, 16'h0000, 4'b0100);
        chk_caps("zero", 7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001);
        chk("zero_dp_mask", 16'(dp_low_mask), 16'h4);
        chk("zero_dp_cnt", 16'(dp_low_cnt), 16'd3);

        // Asynchronous reset in the middle of digit 2.
        blank_lz = 1'b0;
        align();
        repeat (10) step();
        chk("pre_rst_an", 16'(an), 16'hB);
        #2 rst_n = 1'b0;
        #1;
        chk("async_an", 16'(an), 16'hF);
        chk("async_seg7", 16'(seg7), 16'h7F);
        chk("async_dp", 16'(dp), 16'h1);
        chk("async_frame", 16'(frame), 16'h0);
        @(posedge clk);
        @(negedge clk);
        chk("hold_an", 16'(an), 16'hF);
        rst_n = 1'b1;
        model_reset();
        step();
        chk("restart_frame", 16'(frame), 16'h1);
        chk("restart_an", 16'(an), 16'hF);
        chk("restart_seg7", 16'(seg7), 16'(7'b0000001));
        step();
        chk("restart_d0", 16'(an), 16'hE);

        // Random traffic against the model.
        for (int n = 0; n < 640; n++) begin
            logic [15:0] msk;
            case ($urandom_range(0, 4))
                0: msk = 16'hFFFF;
                1: msk = 16'h0FFF;
                2: msk = 16'h00FF;
                3: msk = 16'h000F;
                default: msk = 16'h0000;
            endcase
            load  = ($urandom_range(0, 5) == 0);
            value = 16'($urandom) & msk;
            dp_in = 4'($urandom);
            if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
